// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: operand and accumulator
// widths, controller states and Booth recoding pair values.
package booth_mul_seq_pkg;

  localparam int WIDTH = 8;
  localparam int ACC_W = WIDTH + 1;
  localparam int CNT_W = 3;

  // Counter value of the final Booth iteration.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q[0], q_1} recoding pairs
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_mul_seq_rca.sv
// Ripple-carry adder shared by the multiplier for every add and subtract step.
// Subtraction is done by the caller inverting y and setting ci.
module booth_mul_seq_rca #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf
);

  always_comb begin
    logic carry;
    logic carry_msb;
    s         = '0;
    carry     = ci;
    carry_msb = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) carry_msb = carry;
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co  = carry;
    ovf = carry ^ carry_msb;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed 8x8->16 radix-2 Booth multiplier with a start/done handshake.
// One add/sub plus arithmetic shift per clock through a single shared 9-bit RCA.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_1_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic               accept;
  logic               last_iter;
  logic [1:0]         booth_pair;
  logic [ACC_W-1:0]   rca_y;
  logic               rca_ci;
  logic [ACC_W-1:0]   rca_s;
  logic [ACC_W-1:0]   sum_s;
  logic               rca_co_unused;
  logic               rca_ovf_unused;

  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_iter  = (state_reg == RUN) && (cnt_reg == CNT_LAST);
  assign booth_pair = {q_reg[0], q_1_reg};

  // Operand inversion and carry-in turn the shared adder into a subtractor.
  always_comb begin
    rca_y  = m_reg;
    rca_ci = 1'b0;
    if (booth_pair == BOOTH_SUB) begin
      rca_y  = ~m_reg;
      rca_ci = 1'b1;
    end
  end

  booth_mul_seq_rca #(
    .W (ACC_W)
  ) u_rca (
    .x   (acc_reg),
    .y   (rca_y),
    .ci  (rca_ci),
    .s   (rca_s),
    .co  (rca_co_unused),
    .ovf (rca_ovf_unused)
  );

  always_comb begin
    sum_s = acc_reg;
    case (booth_pair)
      BOOTH_ADD,
      BOOTH_SUB:  sum_s = rca_s;
      BOOTH_NOP0,
      BOOTH_NOP1: sum_s = acc_reg;
      default:    sum_s = acc_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == CNT_LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      m_reg       <= '0;
      q_reg       <= '0;
      q_1_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        m_reg   <= {a[WIDTH-1], a};
        q_reg   <= b;
        acc_reg <= '0;
        q_1_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        {acc_reg, q_reg, q_1_reg} <= {sum_s[ACC_W-1], sum_s, q_reg};
        cnt_reg                   <= cnt_reg + CNT_W'(1);
      end
      // Product taken from the post-shift value so it is valid in the DONE cycle.
      if (last_iter) begin
        product_reg <= {sum_s, q_reg[WIDTH-1:1]};
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: expected products queued at start, checked at done.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q[$];

  booth_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [7:0] ta, input logic [7:0] tbv);
    int p;
    p = int'($signed(ta)) * int'($signed(tbv));
    a     = ta;
    b     = tbv;
    start = 1'b1;
    exp_q.push_back(p[15:0]);
    $display("[TB] start a=%0d b=%0d expect=0x%04h", $signed(ta), $signed(tbv), p[15:0]);
  endtask

  // Waits (bounded) for done, then pops the scoreboard and compares the product.
  task automatic wait_done(input string tag, output int lat, output int busy_cycles);
    logic [15:0] e;
    lat         = 0;
    busy_cycles = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cycles++;
    end while (!done && lat < 30);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    if (done) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check({tag, " product"}, {16'd0, product}, {16'd0, e});
      check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
      $display("[TB] %s done product=0x%04h expect=0x%04h lat=%0d", tag, product, e, lat);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv);
    int lat;
    int bc;
    drive_start(ta, tbv);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
    wait_done(tag, lat, bc);
    check({tag, " latency"}, lat, 32'd8);
    check({tag, " busy cycles"}, bc + 1, 32'd8);
  endtask

  initial begin
    int lat;
    int bc;
    int done_cnt;
    logic [15:0] prev;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("3x5", 8'd3, 8'd5);
    @(posedge clk);
    #1;
    check("3x5 done pulse width", {31'd0, done}, 32'd0);
    check("3x5 product hold", {16'd0, product}, 32'h000F);

    run_op("-7x6", 8'hF9, 8'd6);
    run_op("127x-128", 8'd127, 8'h80);
    run_op("-128x-128", 8'h80, 8'h80);

    // Back-to-back: start issued during the DONE cycle of the previous op.
    prev = product;
    drive_start(8'd2, 8'hFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy@accept", {31'd0, busy}, 32'd1);
    check("b2b first product held", {16'd0, product}, {16'd0, prev});
    wait_done("2x-1", lat, bc);
    check("b2b done spacing", lat + 1, 32'd9);
    @(posedge clk);
    #1;
    check("b2b idle done", {31'd0, done}, 32'd0);
    check("b2b idle busy", {31'd0, busy}, 32'd0);

    // start held high through RUN with operands changing underneath.
    drive_start(8'd3, 8'd5);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      a = 8'h7F - 8'(i);
      b = 8'h80 + 8'(i);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done("hold-start", lat, bc);
    check("hold-start latency", lat, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("hold-start extra done", done_cnt, 32'd0);

    // Reset in the fourth RUN cycle aborts the operation (not queued).
    a     = 8'd50;
    b     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort product", {16'd0, product}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_cnt++;
    end
    check("abort no activity", done_cnt, 32'd0);
    $display("[TB] abort checked, product=0x%04h", product);

    run_op("10x10", 8'd10, 8'd10);
    check("scoreboard empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
